// File: rtl/counter_pkg.sv
// Shared constants and helpers for the mod_counter block.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Bits needed to hold 0..n-1; never less than 1 so a degenerate counter still elaborates.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated prescaler: pulses tick on every PRESCALE-th enabled clock.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  if (PRESCALE <= 1) begin : g_bypass
    logic w_unused;
    assign w_unused = ^{clk, rst, restart};
    assign tick     = en;
  end else begin : g_div
    localparam int PW = cnt_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    // restart aligns the phase with a clear/load so the next step is a full period away
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)         r_cnt <= '0;
      else if (restart) r_cnt <= '0;
      else if (en)      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end

    assign tick = en & w_last & ~restart;
  end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with prescaler, wrap or saturate at the boundary,
// terminal-count pulse and sticky boundary flag.
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 2 || PRESCALE < 1 || MAX_VAL < 0 ||
      longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_params
    $error("mod_counter: illegal WIDTH/MAX_VAL/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_ovf;

  logic             w_tick;
  logic             w_bound;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH-1:0] w_q_load;

  counter_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(clr | load),
    .tick   (w_tick)
  );

  // Boundary depends on direction: top when counting up, zero when counting down.
  assign w_bound  = (dir == DIR_UP) ? (r_q == MAX_Q) : (r_q == '0);
  assign w_q_load = (load_val > MAX_Q) ? MAX_Q : load_val;

  always_comb begin
    w_q_step = r_q;
    if (dir == DIR_UP) begin
      if (!w_bound)       w_q_step = r_q + 1'b1;
      else if (!SATURATE) w_q_step = '0;
    end else begin
      if (!w_bound)       w_q_step = r_q - 1'b1;
      else if (!SATURATE) w_q_step = MAX_Q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q   <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_q   <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (load) begin
      r_q   <= w_q_load;
      r_tc  <= 1'b0;
    end else if (w_tick) begin
      r_q   <= w_q_step;
      r_tc  <= w_bound;
      r_ovf <= r_ovf | w_bound;
    end else begin
      r_tc  <= 1'b0;
    end
  end

  assign q   = r_q;
  assign tc  = r_tc;
  assign ovf = r_ovf;

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits, minimum 2.
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1: top count value; the count range is 0..MAX_VAL.
REQ-003 SHALL have parameter PRESCALE, default 1: enabled clocks per count step, minimum 1.
REQ-004 SHALL have parameter SATURATE, default 0: 0 = wrap at the boundary, 1 = hold at the boundary.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: count enable; also gates the prescaler.
REQ-008 SHALL have port clr, input, 1 bit: synchronous clear.
REQ-009 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-010 SHALL have port load_val, input, WIDTH bits: value to load.
REQ-011 SHALL have port dir, input, 1 bit: 1 = count up, 0 = count down.
REQ-012 SHALL have port q, output, WIDTH bits: registered count value.
REQ-013 SHALL have port tc, output, 1 bit: registered terminal-count pulse.
REQ-014 SHALL have port ovf, output, 1 bit: sticky boundary flag.

Function
REQ-015 SHALL apply priority per clock edge: clr, then load, then count step, then hold.
REQ-016 On clr, SHALL set q=0, prescaler=0 and ovf=0; tc=0 that cycle.
REQ-017 On load (without clr), SHALL set q=min(load_val, MAX_VAL) and prescaler=0; tc unchanged-to-0; ovf unaffected.
REQ-018 SHALL advance the prescaler by 1 on each edge with en=1; a step occurs when prescaler==PRESCALE-1, and the prescaler then returns to 0.
REQ-019 SHALL hold both the prescaler and q while en=0.
REQ-020 With PRESCALE=1, SHALL step on every enabled edge.
REQ-021 On an up-step, SHALL set q=q+1 when q<MAX_VAL; at q==MAX_VAL, q=0 if SATURATE=0, else q holds.
REQ-022 On a down-step, SHALL set q=q-1 when q>0; at q==0, q=MAX_VAL if SATURATE=0, else q holds.
REQ-023 A boundary event is defined as a step taken while q sits at the boundary in the current direction.
REQ-024 On a boundary event, SHALL assert tc for exactly one cycle, coincident with the updated q.
REQ-025 tc SHALL be 0 in all other cycles.
REQ-026 ovf SHALL set on any boundary event and stay set until clr or reset.
REQ-027 dir SHALL be sampled only on step edges; a dir change never alters the prescaler phase.
REQ-028 If q>MAX_VAL can only arise from load, SHALL be prevented by the clamp; q never exceeds MAX_VAL.
REQ-029 All arithmetic SHALL be WIDTH bits, with no internal carry beyond the boundary compare.

Reset
REQ-030 On rst low, SHALL immediately set q=0, tc=0, ovf=0 and prescaler=0, without waiting for a clock edge.
REQ-031 Deassertion of rst SHALL be synchronised externally; the first step occurs PRESCALE enabled edges after release.
REQ-032 Reset asserted mid-count SHALL discard any pending prescaler phase.

Structure
REQ-033 A shared package counter_pkg SHALL hold the DIR_UP/DIR_DOWN constants and a clog2-based helper used for the prescaler width.
REQ-034 The prescaler SHALL be a sub-module counter_prescaler (inputs clk, rst, en, restart; parameter PRESCALE; output tick); with PRESCALE=1 it reduces to tick=en.
REQ-035 Parameter legality (MAX_VAL<=2**WIDTH-1, PRESCALE>=1) SHALL be checked at elaboration.

Verification
REQ-036 WIDTH=8, MAX_VAL=9, PRESCALE=1, up, en=1 from reset: q steps 0..9 then 0; tc high only in the cycle q=0 after 9; ovf=1 thereafter.
REQ-037 Same configuration, dir=0 from q=0: next q=9 with a tc pulse; then q steps 8, 7, ... one per cycle.
REQ-038 SATURATE=1, MAX_VAL=9, up from 8: q=9, then stays 9; tc pulses on every further step attempt.
REQ-039 PRESCALE=4, up, en=1: q increments every 4th edge; en=0 for 3 cycles mid-phase delays the next step by exactly 3 cycles.
REQ-040 load=1 with load_val=15 and MAX_VAL=9 gives q=9; clr and load together give q=0 with ovf cleared.
REQ-041 rst pulled low between clock edges at q=5 forces q=0, tc=0, ovf=0 asynchronously; after release, counting resumes from 0.
